alu_arbiter: RTL and testbench

//   Shares one combinational 8-bit ALU between NUM_REQ requesters using round-robin arbitration.

---
 rtl/alu_arbiter.sv | 174 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between NUM_REQ requesters.
// Ports: clock_in/reset_in, req_* (in), resp_* (out), alu_* (to/from ALU),
// busy_out, txn_count_out. Optional opcode check macro: ALU_ARB_OPCHECK_EN.
module alu_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clock_in,
  input  logic                          reset_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  input  logic [NUM_REQ*OP_WIDTH-1:0]   req_opcode_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_input1_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_input2_in,
  output logic [NUM_REQ-1:0]            resp_valid_out,
  input  logic [NUM_REQ-1:0]            resp_ready_in,
  output logic [DATA_WIDTH-1:0]         resp_data_out,
  output logic                          resp_error_out,
  output logic                          alu_enable_out,
  output logic [OP_WIDTH-1:0]           alu_opcode_out,
  output logic [DATA_WIDTH-1:0]         alu_input1_out,
  output logic [DATA_WIDTH-1:0]         alu_input2_out,
  input  logic [DATA_WIDTH-1:0]         alu_result_in,
  output logic                          busy_out,
  output logic [CNT_WIDTH-1:0]          txn_count_out
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         last_q, last_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
`ifdef ALU_ARB_OPCHECK_EN
  logic                  err_q, err_d;
`endif

  logic                  found;
  logic [IW-1:0]         sel;
  logic [OP_WIDTH-1:0]   sel_op;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic                  illegal;
  int                    idx;

  // Scan starts just after the last completed grant.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && req_valid_in[IW'(idx)]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
  end

  assign sel_op = req_opcode_in[int'(sel)*OP_WIDTH +: OP_WIDTH];
  assign sel_a  = req_input1_in[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_b  = req_input2_in[int'(sel)*DATA_WIDTH +: DATA_WIDTH];

`ifdef ALU_ARB_OPCHECK_EN
  assign illegal = (sel_op > OP_WIDTH'(4));
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    grant_d        = grant_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    data_d         = data_q;
    cnt_d          = cnt_q;
`ifdef ALU_ARB_OPCHECK_EN
    err_d          = err_q;
`endif
    req_ready_out  = '0;
    resp_valid_out = '0;
    alu_enable_out = 1'b0;
    alu_opcode_out = '0;
    alu_input1_out = '0;
    alu_input2_out = '0;
    unique case (state_q)
      IDLE: begin
        // Gated by reset so every output reads 0 while held in reset.
        if (found && reset_in) begin
          req_ready_out = ONE << sel;
          grant_d       = sel;
          op_d          = sel_op;
          a_d           = sel_a;
          b_d           = sel_b;
          if (illegal) begin
            data_d  = '0;
            state_d = RESP;
          end else begin
            state_d = EXEC;
          end
`ifdef ALU_ARB_OPCHECK_EN
          err_d = illegal;
`endif
        end
      end
      EXEC: begin
        alu_enable_out = 1'b1;
        alu_opcode_out = op_q;
        alu_input1_out = a_q;
        alu_input2_out = b_q;
        data_d         = alu_result_in;
        state_d        = RESP;
      end
      RESP: begin
        resp_valid_out = ONE << grant_q;
        if (resp_ready_in[grant_q]) begin
          last_d  = grant_q;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= IDLE;
      last_q  <= IW'(NUM_REQ-1);
      grant_q <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
`ifdef ALU_ARB_OPCHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
`ifdef ALU_ARB_OPCHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign resp_data_out = data_q;
  assign busy_out      = (state_q != IDLE);
  assign txn_count_out = cnt_q;
`ifdef ALU_ARB_OPCHECK_EN
  assign resp_error_out = err_q;
`else
  assign resp_error_out = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
// Uses a small stub ALU and a 4-bit transaction counter.
module tb_alu_arbiter;

  localparam int N  = 4;
  localparam int CW = 4;
`ifdef ALU_ARB_OPCHECK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*8-1:0] req_op;
  logic [N*8-1:0] req_a;
  logic [N*8-1:0] req_b;
  logic [N-1:0]  resp_valid;
  logic [N-1:0]  resp_ready;
  logic [7:0]    resp_data;
  logic          resp_err;
  logic          alu_en;
  logic [7:0]    alu_op;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [7:0]    alu_res;
  logic          busy;
  logic [CW-1:0] cnt;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(8),
    .OP_WIDTH(8), .CNT_WIDTH(CW)
  ) dut (
    .clock_in(clk),
    .reset_in(rst_n),
    .req_valid_in(req_valid),
    .req_ready_out(req_ready),
    .req_opcode_in(req_op),
    .req_input1_in(req_a),
    .req_input2_in(req_b),
    .resp_valid_out(resp_valid),
    .resp_ready_in(resp_ready),
    .resp_data_out(resp_data),
    .resp_error_out(resp_err),
    .alu_enable_out(alu_en),
    .alu_opcode_out(alu_op),
    .alu_input1_out(alu_a),
    .alu_input2_out(alu_b),
    .alu_result_in(alu_res),
    .busy_out(busy),
    .txn_count_out(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(
    input logic [7:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [15:0] m;
    m = a * b;
    case (op)
      8'd0:    return a + b;
      8'd1:    return a - b;
      8'd2:    return m[7:0];
      8'd3:    return a & b;
      8'd4:    return a | b;
      default: return 8'd0;
    endcase
  endfunction

  assign alu_res = alu_f(alu_op, alu_a, alu_b);

  task automatic check(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req();
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
  endtask

  task automatic set_req(
    input int r,
    input logic [7:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    req_op[r*8 +: 8] = op;
    req_a[r*8 +: 8]  = a;
    req_b[r*8 +: 8]  = b;
    req_valid[r]     = 1'b1;
  endtask

  task automatic txn(
    input int r,
    input logic [7:0] op,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] exp_d,
    input logic exp_e,
    input logic skip
  );
    logic [N-1:0] oh;
    oh = N'(1) << r;
    clr_req();
    resp_ready = '0;
    set_req(r, op, a, b);
    #1;
    check("txn_ready", req_ready, oh);
    step();
    clr_req();
    if (!skip) begin
      check("txn_en", alu_en, 1);
      check("txn_op", alu_op, op);
      check("txn_a", alu_a, a);
      check("txn_b", alu_b, b);
      step();
    end
    check("txn_en_off", alu_en, 0);
    check("txn_rv", resp_valid, oh);
    check("txn_data", resp_data, exp_d);
    check("txn_err", resp_err, exp_e);
    resp_ready = oh;
    step();
    resp_ready = '0;
    check("txn_idle", busy, 0);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_rdy"}, req_ready, 0);
    check({tag, "_rv"}, resp_valid, 0);
    check({tag, "_data"}, resp_data, 0);
    check({tag, "_err"}, resp_err, 0);
    check({tag, "_en"}, alu_en, 0);
    check({tag, "_alu"}, {alu_op, alu_a, alu_b}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cnt"}, cnt, 0);
  endtask

  int g[5];
  int t[5];
  int n;
  int cyc;

  initial begin
    rst_n = 1'b0;
    resp_ready = '0;
    clr_req();
    #12;
    chk_zero("rst");
    rst_n = 1'b1;
    step();

    // T1: single transaction on requester 0
    txn(0, 8'd0, 8'd3, 8'd4, 8'd7, 1'b0, 1'b0);
    check("t1_cnt", cnt, 1);

    // fresh reset so contention starts from requester 0
    #2 rst_n = 1'b0;
    #1 chk_zero("rst2");
    rst_n = 1'b1;
    step();

    // T2: all requesters valid, immediate resp_ready
    for (int i = 0; i < N; i++) set_req(i, 8'd0, 8'(i), 8'd10);
    resp_ready = '1;
    n = 0;
    cyc = 0;
    while (n < 5 && cyc < 60) begin
      #1;
      if (req_ready != 0) begin
        for (int k = 0; k < N; k++)
          if (req_ready[k]) g[n] = k;
        t[n] = cyc;
        n++;
      end
      @(posedge clk);
      cyc++;
    end
    #1;
    clr_req();
    check("t2_ngrant", n, 5);
    for (int k = 0; k < 5; k++) begin
      check("t2_grant", g[k], k % N);
      if (k > 0) check("t2_gap", t[k] - t[k-1], 3);
    end
    cyc = 0;
    while (busy && cyc < 10) begin
      step();
      cyc++;
    end
    check("t2_done", busy, 0);
    check("t2_cnt", cnt, 5);
    resp_ready = '0;

    // T3: backpressure on requester 2
    set_req(2, 8'd2, 8'd5, 8'd6);
    #1;
    check("t3_ready", req_ready, 4'b0100);
    step();
    clr_req();
    check("t3_en", alu_en, 1);
    step();
    set_req(0, 8'd0, 8'd1, 8'd1);
    resp_ready = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      check("t3_rv", resp_valid, 4'b0100);
      check("t3_data", resp_data, 30);
      check("t3_busy", busy, 1);
      check("t3_nogrant", req_ready, 0);
      step();
    end
    resp_ready = 4'b0100;
    step();
    resp_ready = '0;
    check("t3_cnt", cnt, 6);
    check("t3_rv_off", resp_valid, 0);
    check("t3_r0_rdy", req_ready, 4'b0001);
    clr_req();
    step();
    check("t3_dropped", busy, 0);

    // T4: reset during EXEC
    set_req(1, 8'd0, 8'd1, 8'd1);
    step();
    clr_req();
    check("t4_exec", alu_en, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("t4_rst");
    #2 rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      check("t4_no_rv", resp_valid, 0);
      check("t4_no_busy", busy, 0);
      step();
    end
    txn(1, 8'd1, 8'd9, 8'd2, 8'd7, 1'b0, 1'b0);
    check("t4_cnt", cnt, 1);

    // T5: counter wrap with 4-bit counter
    for (int i = 0; i < 15; i++) begin
      txn(i % N, 8'(i % 5), 8'(i + 1), 8'd3,
          alu_f(8'(i % 5), 8'(i + 1), 8'd3), 1'b0, 1'b0);
      if (i == 13) check("t5_cnt15", cnt, 15);
    end
    check("t5_wrap", cnt, 0);

    // T6: out-of-range opcode
    txn(3, 8'h09, 8'd1, 8'd1, 8'd0, OPCHK, OPCHK);
    check("t6_cnt", cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
